// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with a dedicated level counter, runtime almost-full/almost-empty thresholds,
// sticky overflow/underflow flags, synchronous flush and standard or first-word-fall-through reads.
`timescale 1ns/1ps
module fifo_sync_flags #(
    parameter int DATA_SIZE  = 16,
    parameter int SIZE       = 8,
    parameter bit FWFT       = 1'b0,
    localparam int ADDR_SIZE = $clog2(SIZE)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_en,
    input  logic                 i_clear,
    input  logic                 i_write,
    input  logic [DATA_SIZE-1:0] i_data,
    input  logic                 i_read,
    input  logic [ADDR_SIZE:0]   i_afull_thr,
    input  logic [ADDR_SIZE:0]   i_aempty_thr,
    output logic [DATA_SIZE-1:0] o_data,
    output logic                 o_rvalid,
    output logic                 o_empty,
    output logic                 o_full,
    output logic                 o_almost_full,
    output logic                 o_almost_empty,
    output logic [ADDR_SIZE:0]   o_level,
    output logic                 o_overflow,
    output logic                 o_underflow
);

    localparam logic [ADDR_SIZE:0]   LVL_FULL = (ADDR_SIZE + 1)'(SIZE);
    localparam logic [ADDR_SIZE-1:0] PTR_LAST = ADDR_SIZE'(SIZE - 1);

    logic [DATA_SIZE-1:0] mem_q [SIZE];
    logic [ADDR_SIZE-1:0] wptr_q, wptr_d;
    logic [ADDR_SIZE-1:0] rptr_q, rptr_d;
    logic [ADDR_SIZE:0]   level_q, level_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;
    logic                 clr;
    logic                 rd_ok;
    logic                 wr_ok;

    // Depth need not be a power of two, so pointers wrap on an explicit compare.
    function automatic logic [ADDR_SIZE-1:0] ptr_inc(input logic [ADDR_SIZE-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign clr   = i_en & i_clear;
    assign rd_ok = i_en & i_read & (level_q != '0);
    assign wr_ok = i_en & i_write & ((level_q < LVL_FULL) | rd_ok);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (wr_ok) wptr_d = ptr_inc(wptr_q);
            if (rd_ok) rptr_d = ptr_inc(rptr_q);
            if (wr_ok && !rd_ok)      level_d = level_q + 1'b1;
            else if (rd_ok && !wr_ok) level_d = level_q - 1'b1;
            if (i_en && i_write && !wr_ok) ovf_d = 1'b1;
            if (i_en && i_read && !rd_ok)  udf_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage has no reset; a flush only moves the pointers.
    always_ff @(posedge i_clk) begin
        if (wr_ok && !clr) mem_q[wptr_q] <= i_data;
    end

    if (!FWFT) begin : g_std
        logic [DATA_SIZE-1:0] rdata_q;
        logic                 rvalid_q;

        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else if (clr) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rd_ok;
                if (rd_ok) rdata_q <= mem_q[rptr_q];
            end
        end

        assign o_data   = rdata_q;
        assign o_rvalid = rvalid_q;
    end else begin : g_fwft
        assign o_data   = mem_q[rptr_q];
        assign o_rvalid = (level_q != '0);
    end

    assign o_level        = level_q;
    assign o_empty        = (level_q == '0);
    assign o_full         = (level_q == LVL_FULL);
    assign o_almost_full  = (level_q >= i_afull_thr);
    assign o_almost_empty = (level_q <= i_aempty_thr);
    assign o_overflow     = ovf_q;
    assign o_underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench for fifo_sync_flags: depth-8 standard, depth-8 FWFT and depth-5 standard instances.
`timescale 1ns/1ps
module tb_fifo_sync_flags;

    logic        clk;
    logic        rst;
    logic        en   [3];
    logic        clr  [3];
    logic        wr   [3];
    logic        rd   [3];
    logic [15:0] din  [3];
    logic [3:0]  aft  [3];
    logic [3:0]  aet  [3];
    logic [15:0] dout [3];
    logic        rv   [3];
    logic        emp  [3];
    logic        ful  [3];
    logic        af   [3];
    logic        ae   [3];
    logic [3:0]  lvl  [3];
    logic        ovf  [3];
    logic        udf  [3];

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] q [$];
    logic [15:0] exp_drain [8];
    logic [15:0] e;

    fifo_sync_flags #(.DATA_SIZE(16), .SIZE(8), .FWFT(1'b0)) u_std8 (
        .i_clk(clk), .i_reset(rst), .i_en(en[0]), .i_clear(clr[0]), .i_write(wr[0]),
        .i_data(din[0]), .i_read(rd[0]), .i_afull_thr(aft[0]), .i_aempty_thr(aet[0]),
        .o_data(dout[0]), .o_rvalid(rv[0]), .o_empty(emp[0]), .o_full(ful[0]),
        .o_almost_full(af[0]), .o_almost_empty(ae[0]), .o_level(lvl[0]),
        .o_overflow(ovf[0]), .o_underflow(udf[0]));

    fifo_sync_flags #(.DATA_SIZE(16), .SIZE(8), .FWFT(1'b1)) u_fwft8 (
        .i_clk(clk), .i_reset(rst), .i_en(en[1]), .i_clear(clr[1]), .i_write(wr[1]),
        .i_data(din[1]), .i_read(rd[1]), .i_afull_thr(aft[1]), .i_aempty_thr(aet[1]),
        .o_data(dout[1]), .o_rvalid(rv[1]), .o_empty(emp[1]), .o_full(ful[1]),
        .o_almost_full(af[1]), .o_almost_empty(ae[1]), .o_level(lvl[1]),
        .o_overflow(ovf[1]), .o_underflow(udf[1]));

    fifo_sync_flags #(.DATA_SIZE(16), .SIZE(5), .FWFT(1'b0)) u_std5 (
        .i_clk(clk), .i_reset(rst), .i_en(en[2]), .i_clear(clr[2]), .i_write(wr[2]),
        .i_data(din[2]), .i_read(rd[2]), .i_afull_thr(aft[2]), .i_aempty_thr(aet[2]),
        .o_data(dout[2]), .o_rvalid(rv[2]), .o_empty(emp[2]), .o_full(ful[2]),
        .o_almost_full(af[2]), .o_almost_empty(ae[2]), .o_level(lvl[2]),
        .o_overflow(ovf[2]), .o_underflow(udf[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int u, input logic w, input logic r, input logic [15:0] d);
        wr[u]  = w;
        rd[u]  = r;
        din[u] = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 3; u++) begin
            en[u] = 1'b1; clr[u] = 1'b0; wr[u] = 1'b0; rd[u] = 1'b0; din[u] = '0;
            aft[u] = 4'd6; aet[u] = 4'd1;
        end
        tick();
        tick();

        // Reset state, depth-8 standard
        check_eq("rst_level",  32'(lvl[0]), 32'd0);
        check_eq("rst_empty",  32'(emp[0]), 32'd1);
        check_eq("rst_full",   32'(ful[0]), 32'd0);
        check_eq("rst_rvalid", 32'(rv[0]),  32'd0);
        check_eq("rst_data",   32'(dout[0]), 32'd0);
        check_eq("rst_ovf",    32'(ovf[0]), 32'd0);
        check_eq("rst_udf",    32'(udf[0]), 32'd0);
        check_eq("rst_aempty", 32'(ae[0]),  32'd1);
        check_eq("rst_afull",  32'(af[0]),  32'd0);
        rst = 1'b0;
        tick();

        // Fill to full, then overflow
        for (int i = 1; i <= 8; i++) begin
            drive(0, 1'b1, 1'b0, 16'(i));
            tick();
            if (i == 5) check_eq("afull_at5", 32'(af[0]), 32'd0);
            if (i == 6) check_eq("afull_at6", 32'(af[0]), 32'd1);
        end
        check_eq("fill_full",  32'(ful[0]), 32'd1);
        check_eq("fill_level", 32'(lvl[0]), 32'd8);
        check_eq("fill_afull", 32'(af[0]),  32'd1);
        check_eq("fill_ovf",   32'(ovf[0]), 32'd0);
        drive(0, 1'b1, 1'b0, 16'h0009);
        tick();
        check_eq("ovf_set",   32'(ovf[0]), 32'd1);
        check_eq("ovf_level", 32'(lvl[0]), 32'd8);

        // Asynchronous reset between edges while writes are still requested
        drive(0, 1'b1, 1'b0, 16'h000A);
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_level", 32'(lvl[0]), 32'd0);
        check_eq("arst_empty", 32'(emp[0]), 32'd1);
        check_eq("arst_full",  32'(ful[0]), 32'd0);
        check_eq("arst_ovf",   32'(ovf[0]), 32'd0);
        #1;
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 16'h0000);

        // Refill, then simultaneous read+write while full
        for (int i = 1; i <= 8; i++) begin
            drive(0, 1'b1, 1'b0, 16'(i));
            tick();
        end
        check_eq("refill_level", 32'(lvl[0]), 32'd8);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b1, 1'b1, 16'hABCD);
            tick();
            check_eq("rw_full_data",   32'(dout[0]), 32'(k + 1));
            check_eq("rw_full_rvalid", 32'(rv[0]),   32'd1);
            check_eq("rw_full_level",  32'(lvl[0]),  32'd8);
            check_eq("rw_full_ovf",    32'(ovf[0]),  32'd0);
        end
        exp_drain = '{16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008,
                      16'hABCD, 16'hABCD, 16'hABCD};
        for (int i = 0; i < 8; i++) begin
            drive(0, 1'b0, 1'b1, 16'h0000);
            tick();
            check_eq("drain_data",   32'(dout[0]), 32'(exp_drain[i]));
            check_eq("drain_rvalid", 32'(rv[0]),   32'd1);
        end
        check_eq("drain_empty", 32'(emp[0]), 32'd1);
        check_eq("drain_level", 32'(lvl[0]), 32'd0);
        drive(0, 1'b0, 1'b0, 16'h0000);
        tick();
        check_eq("idle_rvalid", 32'(rv[0]),   32'd0);
        check_eq("idle_hold",   32'(dout[0]), 32'hABCD);

        // Single-entry standard read with one cycle latency; enable low freezes everything
        drive(0, 1'b1, 1'b0, 16'h1234);
        tick();
        check_eq("one_level", 32'(lvl[0]), 32'd1);
        en[0] = 1'b0;
        drive(0, 1'b1, 1'b1, 16'h9999);
        tick();
        check_eq("dis_level",  32'(lvl[0]),  32'd1);
        check_eq("dis_rvalid", 32'(rv[0]),   32'd0);
        check_eq("dis_data",   32'(dout[0]), 32'hABCD);
        check_eq("dis_ovf",    32'(ovf[0]),  32'd0);
        check_eq("dis_udf",    32'(udf[0]),  32'd0);
        en[0] = 1'b1;
        drive(0, 1'b0, 1'b1, 16'h0000);
        tick();
        check_eq("std_rvalid", 32'(rv[0]),   32'd1);
        check_eq("std_data",   32'(dout[0]), 32'h1234);
        check_eq("std_empty",  32'(emp[0]),  32'd1);
        tick();
        check_eq("std_rvalid_drop", 32'(rv[0]),   32'd0);
        check_eq("std_data_hold",   32'(dout[0]), 32'h1234);
        check_eq("std_udf",         32'(udf[0]),  32'd1);
        drive(0, 1'b0, 1'b0, 16'h0000);

        // Flush with level 3 and both error flags set
        for (int i = 1; i <= 9; i++) begin
            drive(0, 1'b1, 1'b0, 16'(16'h0020 + i));
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b0, 1'b1, 16'h0000);
            tick();
        end
        drive(0, 1'b0, 1'b0, 16'h0000);
        check_eq("pre_clr_level", 32'(lvl[0]), 32'd3);
        check_eq("pre_clr_ovf",   32'(ovf[0]), 32'd1);
        check_eq("pre_clr_udf",   32'(udf[0]), 32'd1);
        clr[0] = 1'b1;
        drive(0, 1'b1, 1'b1, 16'h7777);
        tick();
        clr[0] = 1'b0;
        drive(0, 1'b0, 1'b0, 16'h0000);
        check_eq("clr_level",  32'(lvl[0]),  32'd0);
        check_eq("clr_empty",  32'(emp[0]),  32'd1);
        check_eq("clr_ovf",    32'(ovf[0]),  32'd0);
        check_eq("clr_udf",    32'(udf[0]),  32'd0);
        check_eq("clr_rvalid", 32'(rv[0]),   32'd0);
        check_eq("clr_data",   32'(dout[0]), 32'd0);
        drive(0, 1'b1, 1'b0, 16'h00AA);
        tick();
        check_eq("post_clr_level", 32'(lvl[0]), 32'd1);
        drive(0, 1'b0, 1'b1, 16'h0000);
        tick();
        check_eq("post_clr_data",   32'(dout[0]), 32'h00AA);
        check_eq("post_clr_rvalid", 32'(rv[0]),   32'd1);
        check_eq("post_clr_empty",  32'(emp[0]),  32'd1);
        drive(0, 1'b0, 1'b0, 16'h0000);

        // FWFT instance
        check_eq("fwft_rst_rvalid", 32'(rv[1]),  32'd0);
        check_eq("fwft_rst_empty",  32'(emp[1]), 32'd1);
        drive(1, 1'b1, 1'b0, 16'h5A5A);
        tick();
        drive(1, 1'b0, 1'b0, 16'h0000);
        check_eq("fwft_data",   32'(dout[1]), 32'h5A5A);
        check_eq("fwft_rvalid", 32'(rv[1]),   32'd1);
        tick();
        check_eq("fwft_data_hold", 32'(dout[1]), 32'h5A5A);
        drive(1, 1'b0, 1'b1, 16'h0000);
        tick();
        check_eq("fwft_pop_rvalid", 32'(rv[1]),  32'd0);
        check_eq("fwft_pop_empty",  32'(emp[1]), 32'd1);
        drive(1, 1'b1, 1'b0, 16'h1111);
        tick();
        drive(1, 1'b1, 1'b0, 16'h2222);
        tick();
        check_eq("fwft_head",  32'(dout[1]), 32'h1111);
        check_eq("fwft_level", 32'(lvl[1]),  32'd2);
        drive(1, 1'b0, 1'b1, 16'h0000);
        tick();
        check_eq("fwft_next",        32'(dout[1]), 32'h2222);
        check_eq("fwft_next_rvalid", 32'(rv[1]),   32'd1);
        tick();
        check_eq("fwft_last_rvalid", 32'(rv[1]),  32'd0);
        check_eq("fwft_no_udf",      32'(udf[1]), 32'd0);
        tick();
        check_eq("fwft_udf", 32'(udf[1]), 32'd1);
        drive(1, 1'b0, 1'b0, 16'h0000);

        // Depth-5 instance: pointer wrap, thresholds, read+write while empty
        check_eq("d5_ae_lvl0", 32'(ae[2]), 32'd1);
        drive(2, 1'b1, 1'b1, 16'h0077);
        q.push_back(16'h0077);
        tick();
        check_eq("d5_rw_empty_level",  32'(lvl[2]), 32'd1);
        check_eq("d5_rw_empty_udf",    32'(udf[2]), 32'd1);
        check_eq("d5_rw_empty_rvalid", 32'(rv[2]),  32'd0);
        check_eq("d5_ae_lvl1",         32'(ae[2]),  32'd1);
        for (int k = 0; k < 4; k++) begin
            drive(2, 1'b1, 1'b0, 16'(16'h0100 + k));
            q.push_back(16'(16'h0100 + k));
            tick();
            if (k == 0) check_eq("d5_ae_lvl2", 32'(ae[2]), 32'd0);
        end
        check_eq("d5_full",  32'(ful[2]), 32'd1);
        check_eq("d5_level", 32'(lvl[2]), 32'd5);
        for (int k = 0; k < 12; k++) begin
            drive(2, 1'b1, 1'b1, 16'(16'h0200 + k));
            e = q.pop_front();
            q.push_back(16'(16'h0200 + k));
            tick();
            check_eq("d5_pair_data",  32'(dout[2]), 32'(e));
            check_eq("d5_pair_level", 32'(lvl[2]),  32'd5);
        end
        check_eq("d5_pair_ovf", 32'(ovf[2]), 32'd0);
        for (int k = 0; k < 5; k++) begin
            drive(2, 1'b0, 1'b1, 16'h0000);
            e = q.pop_front();
            tick();
            check_eq("d5_drain_data", 32'(dout[2]), 32'(e));
        end
        drive(2, 1'b0, 1'b0, 16'h0000);
        check_eq("d5_end_empty", 32'(emp[2]), 32'd1);
        check_eq("d5_end_ae",    32'(ae[2]),  32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
- Parametrised synchronous single-clock FIFO; next generation of the team's basic FIFO buffer.
- Adds simultaneous read+write in one cycle, any depth (not only powers of two), a fill-level output and runtime almost-full/almost-empty thresholds.
- Adds sticky overflow/underflow error flags, a synchronous flush, and a selectable standard or first-word-fall-through (FWFT) read mode.
- Sits between accelerator stream producers and consumers on the peripheral side.

Parameters:
- DATA_SIZE, 16, data word width in bits (>=1).
- SIZE, 8, depth in entries (>=2, any integer).
- ADDR_SIZE, $clog2(SIZE), pointer width; derived, never overridden.
- FWFT, 0, read mode: 0 = standard (registered data after read), 1 = first-word-fall-through.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_en  in  1  global enable; 0 = no read, write or error-flag update.
- i_clear  in  1  synchronous flush; empties FIFO and clears error flags; priority over read/write.
- i_write  in  1  write request.
- i_data  in  DATA_SIZE  write data.
- i_read  in  1  read request.
- i_afull_thr  in  ADDR_SIZE+1  almost-full threshold.
- i_aempty_thr  in  ADDR_SIZE+1  almost-empty threshold.
- o_data  out  DATA_SIZE  read data.
- o_rvalid  out  1  o_data is valid.
- o_empty  out  1  level == 0.
- o_full  out  1  level == SIZE.
- o_almost_full  out  1  level >= i_afull_thr.
- o_almost_empty  out  1  level <= i_aempty_thr.
- o_level  out  ADDR_SIZE+1  current entry count, 0..SIZE.
- o_overflow  out  1  sticky: a write was rejected.
- o_underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (async, i_reset=1):
  - Pointers and level go to 0; o_data=0; o_rvalid=0; o_overflow=0; o_underflow=0.
  - Outputs therefore read: o_empty=1, o_full=0, o_level=0.
  - Storage array is not reset. Reset mid-transfer discards all contents immediately.
- Clear: i_clear=1 with i_en=1 has the same effect as reset, applied at the next edge. Storage is not touched and the cycle's read/write are ignored.
- Read accept (rd_ok): i_en & i_read & (level != 0).
- Write accept (wr_ok): i_en & i_write & ((level < SIZE) | rd_ok).
  - When full, a write is accepted only if a read is accepted in the same cycle.
- Read and write are independent; both may be accepted in one cycle.
  - Level update: +1 on write only, -1 on read only, unchanged when both are accepted.
- Empty with read+write in the same cycle: read rejected (underflow set), write accepted, level becomes 1.
- Pointers: write pointer advances on wr_ok, read pointer on rd_ok. Each wraps from SIZE-1 to 0 (explicit compare, not modulo 2^ADDR_SIZE).
- Level is a dedicated counter, never derived from pointer difference. It therefore has no full/empty ambiguity.
- Standard mode (FWFT=0):
  - Accepted read at edge N: head entry registered into o_data at edge N; o_rvalid=1 for the cycle after N.
  - o_rvalid=0 otherwise; o_data holds its last value.
  - Read latency is 1 cycle.
- FWFT mode (FWFT=1):
  - o_data = storage[read pointer] continuously; o_rvalid = !o_empty.
  - i_read acts as a pop/acknowledge.
  - Write into an empty FIFO: data visible on o_data the cycle after the write edge.
- Flags: o_empty, o_full, o_almost_full, o_almost_empty and o_level are combinational from the level register (registered-source), so they reflect the state after the last edge.
  - Thresholds are compared unsigned and may change at any time.
  - i_afull_thr=0 forces almost-full high; i_afull_thr > SIZE forces it low.
- Errors:
  - o_overflow sets on i_en & i_write & !wr_ok.
  - o_underflow sets on i_en & i_read & !rd_ok.
  - Both are sticky until reset or clear. A rejected operation changes no state.
- i_en=0: state frozen, o_rvalid drops to 0 (standard mode), no flag updates.

Test Plan:
- Reset, then write 0x0001..0x0008 (SIZE=8, no reads) -> o_full=1, o_level=8, o_almost_full=1 with thr=6. 9th write -> o_overflow=1, level stays 8.
- From full, read+write 0xABCD together for 3 cycles -> level stays 8, o_overflow stays 0. Drain yields 0x0004..0x0008, then 0xABCD x3, in order.
- FWFT=0: write 0x1234, read at edge N -> o_rvalid=1 and o_data=0x1234 in cycle N+1 only; o_empty=1. Extra read -> o_underflow=1.
- FWFT=1: write 0x5A5A into empty FIFO -> o_data=0x5A5A, o_rvalid=1 next cycle without i_read. Pop -> o_rvalid=0.
- SIZE=5: run 12 write/read pairs -> both pointers wrap correctly and data order is preserved. With i_aempty_thr=1, o_almost_empty=1 at levels 0 and 1 and 0 at level 2.
- Assert i_reset asynchronously mid-burst, and separately i_clear with level=3 and errors set -> level=0, o_empty=1, o_overflow=o_underflow=0; following write/read behaves as from reset.
